// File: rtl/mipi_pkg.sv
// Shared definitions for the CSI-2 packet controller: FSM states, data type
// codes and CRC-16 constants.
package mipi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_PAYLOAD,
        ST_CRC0,
        ST_CRC1,
        ST_DRAIN
    } state_t;

    // Short packet data types (synchronisation events)
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    // Data types at or above this value carry a payload
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    // CRC-16 x^16+x^12+x^5+1; bits arrive LSB first, so the shift register
    // runs right-shifting with the bit-reversed polynomial.
    localparam logic [15:0] CRC_SEED     = 16'hFFFF;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_POLY_REV = 16'h8408;

endpackage

// File: rtl/mipi_crc16.sv
// Combinational single-byte CRC-16 update, byte bits consumed LSB first.
module mipi_crc16
    import mipi_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_work;

    // Eight serial LFSR steps unrolled into one cycle
    always_comb begin
        crc_work = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_work[0] ^ byte_in[i]) begin
                crc_work = (crc_work >> 1) ^ CRC_POLY_REV;
            end else begin
                crc_work = crc_work >> 1;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/mipi_csi_pkt_ctrl.sv
// CSI-2 packet controller: parses one packet per HS burst from the aligned
// byte stream, forwards long-packet payload, decodes sync short packets and
// flags payload CRC and truncation errors.
module mipi_csi_pkt_ctrl
    import mipi_pkg::*;
#(
    parameter int CHECK_CRC  = 1,
    parameter int LINE_CNT_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [7:0]            data,
    output logic                  pix_we,
    output logic [7:0]            pix_data,
    output logic [1:0]            vc,
    output logic [5:0]            dt,
    output logic [15:0]           wc,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  line_start,
    output logic                  line_end,
    output logic [LINE_CNT_W-1:0] line_count,
    output logic                  crc_err,
    output logic                  trunc_err
);

    localparam logic [LINE_CNT_W-1:0] LINE_ONE = {{(LINE_CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    logic [15:0] byte_cnt;
    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic [7:0]  crc_lo;

    mipi_crc16 u_crc (
        .crc_in  (crc_reg),
        .byte_in (data),
        .crc_out (crc_next)
    );

    // Packet FSM with registered payload, event and error outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            crc_reg     <= CRC_SEED;
            crc_lo      <= '0;
            pix_we      <= 1'b0;
            pix_data    <= '0;
            vc          <= '0;
            dt          <= '0;
            wc          <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            line_count  <= '0;
            crc_err     <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            pix_we      <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            crc_err     <= 1'b0;
            trunc_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (we) begin
                        vc      <= data[7:6];
                        dt      <= data[5:0];
                        crc_reg <= CRC_SEED;
                        state   <= ST_HDR1;
                    end
                end

                ST_HDR1: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wc[7:0] <= data;
                        state   <= ST_HDR2;
                    end
                end

                ST_HDR2: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wc[15:8] <= data;
                        state    <= ST_HDR3;
                    end
                end

                // ECC byte is consumed unchecked; packet class decided here
                ST_HDR3: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (dt < DT_LONG_MIN) begin
                        case (dt)
                            DT_FS: begin
                                frame_start <= 1'b1;
                                line_count  <= '0;
                            end
                            DT_FE:   frame_end  <= 1'b1;
                            DT_LS:   line_start <= 1'b1;
                            DT_LE:   line_end   <= 1'b1;
                            default: ;
                        endcase
                        state <= ST_DRAIN;
                    end else if (wc != 16'd0) begin
                        byte_cnt <= wc;
                        state    <= ST_PAYLOAD;
                    end else begin
                        state <= ST_CRC0;
                    end
                end

                ST_PAYLOAD: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        pix_we   <= 1'b1;
                        pix_data <= data;
                        crc_reg  <= crc_next;
                        byte_cnt <= byte_cnt - 16'd1;
                        if (byte_cnt == 16'd1) begin
                            state <= ST_CRC0;
                        end
                    end
                end

                ST_CRC0: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        crc_lo <= data;
                        state  <= ST_CRC1;
                    end
                end

                ST_CRC1: begin
                    if (!we) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        if ((CHECK_CRC != 0) && ({data, crc_lo} != crc_reg)) begin
                            crc_err <= 1'b1;
                        end
                        line_count <= line_count + LINE_ONE;
                        state      <= ST_DRAIN;
                    end
                end

                // Trailer bytes are dropped until the burst ends
                ST_DRAIN: begin
                    if (!we) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
